// File: rtl/ovl_load_ctrl.sv
// ovl_load_ctrl: write-side sequencer for the 8-bank character-overlay RAM.
// Parses the UDP receive word stream into WRITE / COMMIT / CLEAR commands,
// drives the RAM write port and holds the bank shown by the read side.
// Optional feature: define OVL_BANK_LOCK_EN to reject WRITE/CLEAR aimed at
// the bank currently on display (tear-free updates).
module ovl_load_ctrl #(
  parameter logic [15:0] MAGIC     = 16'hC0DE,
  parameter int          BANK_BITS = 3,
  parameter int          OFS_BITS  = 8,
  parameter int          ERR_BITS  = 8
) (
  input  logic                          udp_clk,
  input  logic                          rstn,
  input  logic                          rec_en,
  input  logic [31:0]                   rec_data,
  input  logic                          rec_pkt_done,
  output logic                          ram_wr_en,
  output logic [BANK_BITS+OFS_BITS-1:0] ram_wr_addr,
  output logic [31:0]                   ram_wr_data,
  output logic [BANK_BITS-1:0]          disp_bank,
  output logic                          load_busy,
  output logic                          frame_done,
  output logic [ERR_BITS-1:0]           err_cnt
);

  localparam int AW = BANK_BITS + OFS_BITS;
  localparam int CW = OFS_BITS + 1;

  localparam logic [3:0]          CMD_WRITE  = 4'd1;
  localparam logic [3:0]          CMD_COMMIT = 4'd2;
  localparam logic [3:0]          CMD_CLEAR  = 4'd3;
  localparam logic [OFS_BITS-1:0] OFS_ONE    = {{(OFS_BITS-1){1'b0}}, 1'b1};
  localparam logic [OFS_BITS-1:0] OFS_LAST   = {OFS_BITS{1'b1}};
  localparam logic [OFS_BITS-1:0] OFS_ZERO   = {OFS_BITS{1'b0}};
  localparam logic [CW-1:0]       CNT_ONE    = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]       CNT_ZERO   = {CW{1'b0}};
  localparam logic [CW-1:0]       LEN_MAX    = {1'b1, {OFS_BITS{1'b0}}};
  localparam logic [ERR_BITS-1:0] ERR_ONE    = {{(ERR_BITS-1){1'b0}}, 1'b1};
  localparam logic [ERR_BITS-1:0] ERR_MAX    = {ERR_BITS{1'b1}};

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEN   = 3'd1,
    ST_DATA  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_CLEAR = 3'd4
  } state_t;

  state_t                state_r, state_n;
  logic [BANK_BITS-1:0]  bank_r, bank_n;
  logic [OFS_BITS-1:0]   ofs_r, ofs_n;
  logic [CW-1:0]         cnt_r, cnt_n;
  logic                  pkt_seen_r, pkt_seen_n;
  logic [BANK_BITS-1:0]  disp_bank_r, disp_bank_n;
  logic                  wr_en_r, wr_en_n;
  logic [AW-1:0]         wr_addr_r, wr_addr_n;
  logic [31:0]           wr_data_r, wr_data_n;
  logic                  frame_done_r, frame_done_n;
  logic                  busy_r;
  logic [ERR_BITS-1:0]   err_r;
  logic                  err_inc_s;

  // Header field decode of the current word.
  logic [15:0]           hdr_tag_s;
  logic [3:0]            hdr_cmd_s;
  logic [BANK_BITS-1:0]  hdr_bank_s;
  logic [OFS_BITS-1:0]   hdr_ofs_s;
  logic [CW-1:0]         len_s;
  logic                  lock_hit_s;

  assign hdr_tag_s  = rec_data[31:16];
  assign hdr_cmd_s  = rec_data[15:12];
  assign hdr_bank_s = rec_data[9 +: BANK_BITS];
  assign hdr_ofs_s  = rec_data[OFS_BITS-1:0];
  assign len_s      = rec_data[CW-1:0];

`ifdef OVL_BANK_LOCK_EN
  assign lock_hit_s = (hdr_bank_s == disp_bank_r);
`else
  assign lock_hit_s = 1'b0;
`endif

  // Next-state, write-port and error decisions; a word is processed first,
  // then an end-of-packet seen in the same cycle is applied on top.
  always_comb begin
    state_n      = state_r;
    bank_n       = bank_r;
    ofs_n        = ofs_r;
    cnt_n        = cnt_r;
    pkt_seen_n   = pkt_seen_r;
    disp_bank_n  = disp_bank_r;
    wr_en_n      = 1'b0;
    wr_addr_n    = wr_addr_r;
    wr_data_n    = wr_data_r;
    frame_done_n = 1'b0;
    err_inc_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (rec_en) begin
          if (hdr_tag_s != MAGIC) begin
            err_inc_s = 1'b1;
            state_n   = ST_DRAIN;
          end else begin
            case (hdr_cmd_s)
              CMD_WRITE: begin
                if (lock_hit_s) begin
                  err_inc_s = 1'b1;
                  state_n   = ST_DRAIN;
                end else begin
                  bank_n  = hdr_bank_s;
                  ofs_n   = hdr_ofs_s;
                  state_n = ST_LEN;
                end
              end
              CMD_COMMIT: begin
                disp_bank_n  = hdr_bank_s;
                frame_done_n = 1'b1;
                state_n      = ST_DRAIN;
              end
              CMD_CLEAR: begin
                if (lock_hit_s) begin
                  err_inc_s = 1'b1;
                  state_n   = ST_DRAIN;
                end else begin
                  bank_n     = hdr_bank_s;
                  ofs_n      = OFS_ZERO;
                  pkt_seen_n = 1'b0;
                  state_n    = ST_CLEAR;
                end
              end
              default: begin
                err_inc_s = 1'b1;
                state_n   = ST_DRAIN;
              end
            endcase
          end
          if (rec_pkt_done) begin
            case (state_n)
              ST_LEN: begin
                err_inc_s = 1'b1;
                state_n   = ST_IDLE;
              end
              ST_CLEAR: pkt_seen_n = 1'b1;
              default:  state_n    = ST_IDLE;
            endcase
          end else begin
            pkt_seen_n = pkt_seen_n;
          end
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_LEN: begin
        if (rec_en) begin
          if ((len_s == CNT_ZERO) || (len_s > LEN_MAX)) begin
            err_inc_s = 1'b1;
            state_n   = ST_DRAIN;
          end else begin
            cnt_n   = len_s;
            state_n = ST_DATA;
          end
        end else begin
          state_n = ST_LEN;
        end
        if (rec_pkt_done) begin
          if (state_n != ST_DRAIN) begin
            err_inc_s = 1'b1;
          end else begin
            err_inc_s = err_inc_s;
          end
          state_n = ST_IDLE;
        end else begin
          state_n = state_n;
        end
      end
      ST_DATA: begin
        if (rec_en) begin
          wr_en_n   = 1'b1;
          wr_addr_n = {bank_r, ofs_r};
          wr_data_n = rec_data;
          ofs_n     = ofs_r + OFS_ONE;
          cnt_n     = cnt_r - CNT_ONE;
          if (cnt_r == CNT_ONE) begin
            state_n = ST_DRAIN;
          end else begin
            state_n = ST_DATA;
          end
        end else begin
          state_n = ST_DATA;
        end
        if (rec_pkt_done) begin
          if (state_n != ST_DRAIN) begin
            err_inc_s = 1'b1;
          end else begin
            err_inc_s = 1'b0;
          end
          state_n = ST_IDLE;
        end else begin
          state_n = state_n;
        end
      end
      ST_DRAIN: begin
        if (rec_pkt_done) begin
          state_n = ST_IDLE;
        end else begin
          state_n = ST_DRAIN;
        end
      end
      ST_CLEAR: begin
        wr_en_n   = 1'b1;
        wr_addr_n = {bank_r, ofs_r};
        wr_data_n = 32'h0000_0000;
        ofs_n     = ofs_r + OFS_ONE;
        if (rec_pkt_done) begin
          pkt_seen_n = 1'b1;
          err_inc_s  = pkt_seen_r;
        end else begin
          pkt_seen_n = pkt_seen_r;
        end
        if (ofs_r == OFS_LAST) begin
          state_n = pkt_seen_n ? ST_IDLE : ST_DRAIN;
        end else begin
          state_n = ST_CLEAR;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // State, datapath and registered outputs; error count saturates.
  always_ff @(posedge udp_clk or negedge rstn) begin
    if (!rstn) begin
      state_r      <= ST_IDLE;
      bank_r       <= {BANK_BITS{1'b0}};
      ofs_r        <= OFS_ZERO;
      cnt_r        <= CNT_ZERO;
      pkt_seen_r   <= 1'b0;
      disp_bank_r  <= {BANK_BITS{1'b0}};
      wr_en_r      <= 1'b0;
      wr_addr_r    <= {AW{1'b0}};
      wr_data_r    <= 32'h0000_0000;
      frame_done_r <= 1'b0;
      busy_r       <= 1'b0;
      err_r        <= {ERR_BITS{1'b0}};
    end else begin
      state_r      <= state_n;
      bank_r       <= bank_n;
      ofs_r        <= ofs_n;
      cnt_r        <= cnt_n;
      pkt_seen_r   <= pkt_seen_n;
      disp_bank_r  <= disp_bank_n;
      wr_en_r      <= wr_en_n;
      wr_addr_r    <= wr_addr_n;
      wr_data_r    <= wr_data_n;
      frame_done_r <= frame_done_n;
      busy_r       <= (state_n != ST_IDLE);
      if (err_inc_s && (err_r != ERR_MAX)) begin
        err_r <= err_r + ERR_ONE;
      end else begin
        err_r <= err_r;
      end
    end
  end

  assign ram_wr_en   = wr_en_r;
  assign ram_wr_addr = wr_addr_r;
  assign ram_wr_data = wr_data_r;
  assign disp_bank   = disp_bank_r;
  assign load_busy   = busy_r;
  assign frame_done  = frame_done_r;
  assign err_cnt     = err_r;

endmodule

// File: tb/tb_ovl_load_ctrl.sv
// Directed self-checking bench for ovl_load_ctrl.
module tb_ovl_load_ctrl;

  logic        udp_clk;
  logic        rstn;
  logic        rec_en;
  logic [31:0] rec_data;
  logic        rec_pkt_done;
  logic        ram_wr_en;
  logic [10:0] ram_wr_addr;
  logic [31:0] ram_wr_data;
  logic [2:0]  disp_bank;
  logic        load_busy;
  logic        frame_done;
  logic [7:0]  err_cnt;

  int checks;
  int errors;

  ovl_load_ctrl dut (
    .udp_clk      (udp_clk),
    .rstn         (rstn),
    .rec_en       (rec_en),
    .rec_data     (rec_data),
    .rec_pkt_done (rec_pkt_done),
    .ram_wr_en    (ram_wr_en),
    .ram_wr_addr  (ram_wr_addr),
    .ram_wr_data  (ram_wr_data),
    .disp_bank    (disp_bank),
    .load_busy    (load_busy),
    .frame_done   (frame_done),
    .err_cnt      (err_cnt)
  );

  initial udp_clk = 1'b0;
  always #5 udp_clk = ~udp_clk;

  // Count a comparison and report a mismatch.
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] hdr(input logic [3:0] cmd, input logic [2:0] bank,
                                      input logic [7:0] ofs);
    return {16'hC0DE, cmd, bank, 1'b0, ofs};
  endfunction

  // Present one input cycle; returns #1 after the edge that sampled it.
  task automatic send(input logic en, input logic [31:0] d, input logic done);
    rec_en       = en;
    rec_data     = d;
    rec_pkt_done = done;
    @(posedge udp_clk);
    #1;
    rec_en       = 1'b0;
    rec_data     = 32'h0;
    rec_pkt_done = 1'b0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    @(posedge udp_clk);
    #1;
    rstn = 1'b1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_outs"}, {ram_wr_en, ram_wr_addr, disp_bank, load_busy, frame_done, err_cnt},
        32'h0);
    chk({tag, "_wdata"}, ram_wr_data, 32'h0);
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    rec_en       = 1'b0;
    rec_data     = 32'h0;
    rec_pkt_done = 1'b0;
    rstn         = 1'b0;
    #12;
    rstn = 1'b1;
    #1;
    chk_all_zero("reset");

    // Write to the displayed bank (bank 0).
    send(1'b1, hdr(4'd1, 3'd0, 8'h00), 1'b0);
    send(1'b1, 32'h0000_0001, 1'b0);
    send(1'b1, 32'h0000_0055, 1'b1);
`ifdef OVL_BANK_LOCK_EN
    chk("lock_wr_en", ram_wr_en, 1'b0);
    chk("lock_err", err_cnt, 8'd1);
`else
    chk("nolock_wr", {ram_wr_en, ram_wr_addr}, {1'b1, 11'h000});
    chk("nolock_data", ram_wr_data, 32'h0000_0055);
    chk("nolock_err", err_cnt, 8'd0);
`endif
    send(1'b0, 32'h0, 1'b0);
    chk("lock_idle", {ram_wr_en, load_busy}, 2'b00);
    do_reset();

    // WRITE bank 2 offset 0x10, three words.
    send(1'b1, hdr(4'd1, 3'd2, 8'h10), 1'b0);
    chk("w1_hdr", {ram_wr_en, load_busy}, 2'b01);
    send(1'b1, 32'h0000_0003, 1'b0);
    chk("w1_len", ram_wr_en, 1'b0);
    send(1'b1, 32'h0000_000A, 1'b0);
    chk("w1_a", {ram_wr_en, ram_wr_addr}, {1'b1, 11'h210});
    chk("w1_a_d", ram_wr_data, 32'h0000_000A);
    send(1'b1, 32'h0000_000B, 1'b0);
    chk("w1_b", {ram_wr_en, ram_wr_addr}, {1'b1, 11'h211});
    chk("w1_b_d", ram_wr_data, 32'h0000_000B);
    send(1'b1, 32'h0000_000C, 1'b1);
    chk("w1_c", {ram_wr_en, ram_wr_addr}, {1'b1, 11'h212});
    chk("w1_c_d", ram_wr_data, 32'h0000_000C);
    chk("w1_end", {load_busy, err_cnt}, 9'h000);
    send(1'b0, 32'h0, 1'b0);
    chk("w1_idle", ram_wr_en, 1'b0);

    // WRITE bank 1 offset 0xFE, four words wrapping inside the bank.
    send(1'b1, hdr(4'd1, 3'd1, 8'hFE), 1'b0);
    send(1'b1, 32'h0000_0004, 1'b0);
    send(1'b1, 32'h1111_0001, 1'b0);
    chk("w2_0", {ram_wr_en, ram_wr_addr}, {1'b1, 11'h1FE});
    send(1'b1, 32'h1111_0002, 1'b0);
    chk("w2_1", {ram_wr_en, ram_wr_addr}, {1'b1, 11'h1FF});
    send(1'b1, 32'h1111_0003, 1'b0);
    chk("w2_2", {ram_wr_en, ram_wr_addr}, {1'b1, 11'h100});
    send(1'b1, 32'h1111_0004, 1'b0);
    chk("w2_3", {ram_wr_en, ram_wr_addr}, {1'b1, 11'h101});
    chk("w2_3_d", ram_wr_data, 32'h1111_0004);
    send(1'b1, 32'h1111_0005, 1'b1);
    chk("w2_extra", ram_wr_en, 1'b0);
    chk("w2_end", {load_busy, err_cnt}, 9'h000);

    // COMMIT bank 5 as a single-word packet.
    send(1'b1, hdr(4'd2, 3'd5, 8'h00), 1'b1);
    chk("cm_disp", disp_bank, 3'd5);
    chk("cm_fd", {frame_done, load_busy}, 2'b10);
    send(1'b0, 32'h0, 1'b0);
    chk("cm_fd_off", {frame_done, load_busy}, 2'b00);

    // CLEAR bank 3; a second packet arrives during the clear.
    send(1'b1, hdr(4'd3, 3'd3, 8'h00), 1'b1);
    chk("clr_start", {ram_wr_en, load_busy}, 2'b01);
    for (int i = 0; i < 256; i++) begin
      if (i == 20)      send(1'b1, hdr(4'd1, 3'd3, 8'h00), 1'b0);
      else if (i == 21) send(1'b1, 32'h0000_0010, 1'b0);
      else if (i == 22) send(1'b1, 32'hDEAD_BEEF, 1'b1);
      else              send(1'b0, 32'h0, 1'b0);
      chk("clr_wr", {ram_wr_en, ram_wr_addr}, {1'b1, 11'h300 + 11'(i)});
      chk("clr_data", ram_wr_data, 32'h0);
    end
    chk("clr_end", {load_busy, err_cnt}, {1'b0, 8'd1});
    send(1'b0, 32'h0, 1'b0);
    chk("clr_idle", ram_wr_en, 1'b0);

    // Protocol errors.
    do_reset();
    send(1'b1, 32'hBEEF_1400, 1'b1);
    chk("e_tag", {load_busy, err_cnt}, {1'b0, 8'd1});
    send(1'b1, hdr(4'd1, 3'd2, 8'h00), 1'b0);
    send(1'b1, 32'h0000_0000, 1'b1);
    chk("e_len0", {load_busy, err_cnt}, {1'b0, 8'd2});
    send(1'b1, hdr(4'd1, 3'd4, 8'h00), 1'b0);
    send(1'b1, 32'h0000_0005, 1'b0);
    send(1'b1, 32'h4444_0000, 1'b0);
    chk("e_sh_w0", {ram_wr_en, ram_wr_addr}, {1'b1, 11'h400});
    send(1'b1, 32'h4444_0001, 1'b0);
    chk("e_sh_w1", {ram_wr_en, ram_wr_addr}, {1'b1, 11'h401});
    send(1'b0, 32'h0, 1'b1);
    chk("e_short", {ram_wr_en, load_busy, err_cnt}, {2'b00, 8'd3});
    for (int i = 0; i < 300; i++) begin
      send(1'b1, 32'hBEEF_1000, 1'b1);
    end
    chk("e_sat", err_cnt, 8'd255);

    // Reset in the middle of a DATA burst.
    send(1'b1, hdr(4'd2, 3'd5, 8'h00), 1'b1);
    send(1'b1, hdr(4'd1, 3'd6, 8'h00), 1'b0);
    send(1'b1, 32'h0000_0004, 1'b0);
    send(1'b1, 32'h6666_0000, 1'b0);
    chk("rst_pre", {ram_wr_en, disp_bank, load_busy}, {1'b1, 3'd5, 1'b1});
    #2;
    rstn = 1'b0;
    #1;
    chk_all_zero("rst_async");
    @(posedge udp_clk);
    #1;
    rstn = 1'b1;
    send(1'b1, hdr(4'd1, 3'd6, 8'h07), 1'b0);
    send(1'b1, 32'h0000_0001, 1'b0);
    send(1'b1, 32'h0000_0077, 1'b1);
    chk("rst_post", {ram_wr_en, ram_wr_addr, load_busy, err_cnt}, {1'b1, 11'h607, 1'b0, 8'd0});
    chk("rst_post_d", ram_wr_data, 32'h0000_0077);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
